// File: rtl/mem_arbiter.sv
// Two-port (I/D cache) block-fill arbiter: optional write-back, then fill read, round-robin on ties.
// Latency load->ready = 3 cycles + memory wait states (+1 + waits with evict); memory stalls by withholding mem_ack.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_evict,
  input  logic [ADDR_W-1:0]  i_load_addr,
  input  logic [ADDR_W-1:0]  i_evict_addr,
  input  logic [BLOCK_W-1:0] i_evict_block,
  input  logic               d_load,
  input  logic               d_evict,
  input  logic [ADDR_W-1:0]  d_load_addr,
  input  logic [ADDR_W-1:0]  d_evict_addr,
  input  logic [BLOCK_W-1:0] d_evict_block,
  output logic               i_ready,
  output logic               d_ready,
  output logic [BLOCK_W-1:0] fill_block,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, WB, FILL, RESP, COOL} state_t;

  state_t              state;
  logic                last_i;
  logic                gnt_i;
  logic [ADDR_W-5:0]   load_hi;

  logic                pick_i;
  logic                sel_evict;
  logic [ADDR_W-5:0]   sel_load_hi;
  logic [ADDR_W-5:0]   sel_evict_hi;
  logic [BLOCK_W-1:0]  sel_block;

  // Memory is block-addressed, so the byte offset within a block is dropped on entry.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_load_addr[3:0], i_evict_addr[3:0],
                              d_load_addr[3:0], d_evict_addr[3:0]};

  // On a tie the port that was not granted last wins; last_i resets to 1 so D wins first.
  always_comb begin
    pick_i       = i_load && (!d_load || !last_i);
    sel_evict    = pick_i ? i_evict : d_evict;
    sel_load_hi  = pick_i ? i_load_addr[ADDR_W-1:4]  : d_load_addr[ADDR_W-1:4];
    sel_evict_hi = pick_i ? i_evict_addr[ADDR_W-1:4] : d_evict_addr[ADDR_W-1:4];
    sel_block    = pick_i ? i_evict_block : d_evict_block;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_i     <= 1'b1;
      gnt_i      <= 1'b0;
      load_hi    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fill_block <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_load || d_load) begin
            gnt_i   <= pick_i;
            last_i  <= pick_i;
            load_hi <= sel_load_hi;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            if (sel_evict) begin
              state     <= WB;
              mem_we    <= 1'b1;
              mem_addr  <= {sel_evict_hi, 4'b0};
              mem_wdata <= sel_block;
            end else begin
              state    <= FILL;
              mem_we   <= 1'b0;
              mem_addr <= {sel_load_hi, 4'b0};
            end
          end
        end
        // mem_req stays high across WB->FILL; only the command fields change.
        WB: begin
          if (mem_ack) begin
            state    <= FILL;
            mem_we   <= 1'b0;
            mem_addr <= {load_hi, 4'b0};
          end
        end
        FILL: begin
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            fill_block <= mem_rdata;
            i_ready    <= gnt_i;
            d_ready    <= !gnt_i;
          end
        end
        RESP: begin
          state   <= COOL;
          i_ready <= 1'b0;
          d_ready <= 1'b0;
        end
        // Requester is still dropping load this cycle, so loads are not sampled here.
        COOL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single-port transactions plus tie, reset and spurious-ack sequences.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_load, i_evict, d_load, d_evict;
  logic [AW-1:0] i_load_addr, i_evict_addr, d_load_addr, d_evict_addr;
  logic [BW-1:0] i_evict_block, d_evict_block;
  logic          i_ready, d_ready;
  logic [BW-1:0] fill_block;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          busy;

  int passed = 0;
  int total  = 0;

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clk(clk), .reset(reset),
    .i_load(i_load), .i_evict(i_evict), .i_load_addr(i_load_addr),
    .i_evict_addr(i_evict_addr), .i_evict_block(i_evict_block),
    .d_load(d_load), .d_evict(d_evict), .d_load_addr(d_load_addr),
    .d_evict_addr(d_evict_addr), .d_evict_block(d_evict_block),
    .i_ready(i_ready), .d_ready(d_ready), .fill_block(fill_block),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            port_i;
    bit            evict;
    logic [AW-1:0] load_addr;
    logic [AW-1:0] evict_addr;
    logic [BW-1:0] block;
    logic [BW-1:0] rdata;
    int            wb_delay;
    int            fill_delay;
    logic [AW-1:0] exp_wb_addr;
    logic [AW-1:0] exp_fill_addr;
    int            exp_lat;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int ticks;
    check({tag, "_start_idle"}, {127'b0, busy}, 128'd0);
    if (v.port_i) begin
      i_load = 1'b1; i_evict = v.evict; i_load_addr = v.load_addr;
      i_evict_addr = v.evict_addr; i_evict_block = v.block;
      d_load = 1'b0; d_evict = 1'b1; d_load_addr = ~v.load_addr;
      d_evict_addr = ~v.evict_addr; d_evict_block = ~v.block;
    end else begin
      d_load = 1'b1; d_evict = v.evict; d_load_addr = v.load_addr;
      d_evict_addr = v.evict_addr; d_evict_block = v.block;
      i_load = 1'b0; i_evict = 1'b1; i_load_addr = ~v.load_addr;
      i_evict_addr = ~v.evict_addr; i_evict_block = ~v.block;
    end
    tick(); ticks = 1;
    // After the grant, scramble the granted port's inputs: they must be ignored.
    if (v.port_i) begin
      i_evict = ~v.evict; i_load_addr = ~v.load_addr;
      i_evict_addr = ~v.evict_addr; i_evict_block = ~v.block;
    end else begin
      d_evict = ~v.evict; d_load_addr = ~v.load_addr;
      d_evict_addr = ~v.evict_addr; d_evict_block = ~v.block;
    end
    if (v.evict) begin
      check({tag, "_wb_cmd"}, {126'b0, mem_req, mem_we}, 128'd3);
      check({tag, "_wb_addr"}, {96'b0, mem_addr}, {96'b0, v.exp_wb_addr});
      check({tag, "_wb_data"}, mem_wdata, v.block);
      for (int k = 0; k < v.wb_delay; k++) begin
        tick(); ticks++;
        check({tag, "_wb_hold"}, {94'b0, mem_req, mem_we, mem_addr}, {94'b0, 2'b11, v.exp_wb_addr});
      end
      mem_ack = 1'b1;
      tick(); ticks++;
      mem_ack = 1'b0;
    end
    check({tag, "_fill_cmd"}, {124'b0, mem_req, mem_we, i_ready, d_ready}, 128'd8);
    check({tag, "_fill_addr"}, {96'b0, mem_addr}, {96'b0, v.exp_fill_addr});
    for (int k = 0; k < v.fill_delay; k++) begin
      tick(); ticks++;
      check({tag, "_fill_hold"}, {92'b0, mem_req, mem_we, mem_addr, i_ready, d_ready},
            {92'b0, 2'b10, v.exp_fill_addr, 2'b00});
    end
    mem_ack = 1'b1; mem_rdata = v.rdata;
    tick(); ticks++;
    mem_ack = 1'b0; mem_rdata = '0;
    check({tag, "_latency"}, 128'(ticks + 1), 128'(v.exp_lat));
    check({tag, "_ready"}, {126'b0, i_ready, d_ready}, {126'b0, v.port_i, ~v.port_i});
    check({tag, "_fill_block"}, fill_block, v.rdata);
    check({tag, "_resp_noreq"}, {127'b0, mem_req}, 128'd0);
    i_load = 1'b0; d_load = 1'b0;
    tick();
    check({tag, "_cool"}, {124'b0, i_ready, d_ready, busy, mem_req}, 128'd2);
    tick();
    check({tag, "_back_idle"}, {125'b0, i_ready, d_ready, busy}, 128'd0);
  endtask

  // Both ports request together; memory acks immediately with {4{mem_addr}}.
  task automatic tie_round(input string tag);
    int d_t = 0, i_t = 0, d_cnt = 0, i_cnt = 0, both = 0;
    check({tag, "_start_idle"}, {127'b0, busy}, 128'd0);
    i_load = 1'b1; i_evict = 1'b0; i_load_addr = 32'h0000_1004;
    d_load = 1'b1; d_evict = 1'b0; d_load_addr = 32'h0000_2008;
    mem_ack = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (i_ready && d_ready) both++;
      if (d_ready) begin
        d_cnt++; d_t = t; d_load = 1'b0;
        check({tag, "_d_fill"}, fill_block, {4{32'h0000_2000}});
      end
      if (i_ready) begin
        i_cnt++; i_t = t; i_load = 1'b0;
        check({tag, "_i_fill"}, fill_block, {4{32'h0000_1000}});
      end
      mem_ack = mem_req;
      mem_rdata = {4{mem_addr}};
    end
    mem_ack = 1'b0; mem_rdata = '0;
    check({tag, "_d_time"}, 128'(d_t), 128'd2);
    check({tag, "_i_time"}, 128'(i_t), 128'd6);
    check({tag, "_d_pulses"}, 128'(d_cnt), 128'd1);
    check({tag, "_i_pulses"}, 128'(i_cnt), 128'd1);
    check({tag, "_both_ready"}, 128'(both), 128'd0);
  endtask

  initial begin
    vecs[0] = '{port_i: 1'b0, evict: 1'b0, load_addr: 32'h0000_1234, evict_addr: 32'h0000_0000,
                block: {4{32'h1111_2222}}, rdata: {16{8'hA5}}, wb_delay: 0, fill_delay: 1,
                exp_wb_addr: 32'h0, exp_fill_addr: 32'h0000_1230, exp_lat: 4};
    vecs[1] = '{port_i: 1'b1, evict: 1'b1, load_addr: 32'h0000_0020, evict_addr: 32'h0040_8010,
                block: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, rdata: {4{32'hC0DE_0001}},
                wb_delay: 0, fill_delay: 0,
                exp_wb_addr: 32'h0040_8010, exp_fill_addr: 32'h0000_0020, exp_lat: 4};
    vecs[2] = '{port_i: 1'b1, evict: 1'b0, load_addr: 32'hDEAD_BEEF, evict_addr: 32'h0000_0000,
                block: '0, rdata: {4{32'h5A5A_F00D}}, wb_delay: 0, fill_delay: 10,
                exp_wb_addr: 32'h0, exp_fill_addr: 32'hDEAD_BEE0, exp_lat: 13};
    vecs[3] = '{port_i: 1'b0, evict: 1'b1, load_addr: 32'hFFFF_FFFF, evict_addr: 32'h1234_567F,
                block: {8{16'hBEEF}}, rdata: {4{32'h8000_0001}}, wb_delay: 2, fill_delay: 0,
                exp_wb_addr: 32'h1234_5670, exp_fill_addr: 32'hFFFF_FFF0, exp_lat: 6};

    reset = 1'b0;
    i_load = 1'b0; i_evict = 1'b0; i_load_addr = '0; i_evict_addr = '0; i_evict_block = '0;
    d_load = 1'b0; d_evict = 1'b0; d_load_addr = '0; d_evict_addr = '0; d_evict_block = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    #1;
    check("reset_ctrl", {123'b0, mem_req, mem_we, busy, i_ready, d_ready}, 128'd0);
    check("reset_addr", {96'b0, mem_addr}, 128'd0);
    check("reset_wdata", mem_wdata, 128'd0);
    check("reset_fill", fill_block, 128'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Spurious ack while idle.
    mem_ack = 1'b1; mem_rdata = '1;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("spur_ctrl", {124'b0, busy, mem_req, i_ready, d_ready}, 128'd0);
    check("spur_fill", fill_block, 128'd0);
    tick();
    check("spur_ctrl2", {124'b0, busy, mem_req, i_ready, d_ready}, 128'd0);

    for (int n = 0; n < 4; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tie_round("tie1");
    tie_round("tie2");

    // Reset asserted mid write-back, then a stray ack after release.
    i_load = 1'b1; i_evict = 1'b1; i_evict_addr = 32'h0000_3000; i_load_addr = 32'h0000_4000;
    i_evict_block = {4{32'h7777_7777}};
    tick();
    check("rst_wb_active", {126'b0, mem_req, mem_we}, 128'd3);
    reset = 1'b0;
    #1;
    check("rst_wb_ctrl", {123'b0, mem_req, mem_we, busy, i_ready, d_ready}, 128'd0);
    check("rst_wb_addr", {96'b0, mem_addr}, 128'd0);
    check("rst_wb_wdata", mem_wdata, 128'd0);
    check("rst_wb_fill", fill_block, 128'd0);
    i_load = 1'b0; i_evict = 1'b0;
    tick();
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = '1;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("stray_ack", {124'b0, busy, mem_req, i_ready, d_ready}, 128'd0);
    tick();
    check("stray_ack2", {124'b0, busy, mem_req, i_ready, d_ready}, 128'd0);
    run_vec(vecs[0], "recover");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter BLOCK_W, default 128, block width (4 words).
REQ-003 SHALL have ports: clk  in  1  sole clock, all state on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 i_load, i_evict  in  1 each  instruction-cache block-fill request and dirty-eviction flag.
REQ-006 i_load_addr, i_evict_addr  in  ADDR_W each  fill and victim addresses.
REQ-007 i_evict_block  in  BLOCK_W  victim data.
REQ-008 d_load, d_evict, d_load_addr, d_evict_addr, d_evict_block  in  same widths  data-cache equivalents.
REQ-009 i_ready, d_ready  out  1 each  one-cycle fill-complete pulse per port.
REQ-010 fill_block  out  BLOCK_W  fill data, valid while i_ready or d_ready is high.
REQ-011 mem_req  out  1  main-memory request.
REQ-012 mem_we  out  1  1 = write-back, 0 = fill read.
REQ-013 mem_addr  out  ADDR_W  block-aligned memory address.
REQ-014 mem_wdata  out  BLOCK_W  write-back data.
REQ-015 mem_rdata  in  BLOCK_W  read data, valid with mem_ack.
REQ-016 mem_ack  in  1  one-cycle completion pulse from memory.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 SHALL run FSM states IDLE, WB, FILL, RESP, COOL.
REQ-019 IDLE: a port is pending when its load is 1; no pending port -> stay IDLE.
REQ-020 One port pending -> grant it; both pending -> grant the port not granted last (round-robin); after reset the D port wins the first tie.
REQ-021 On grant SHALL latch evict flag, both addresses and evict block of the granted port; later changes on that port are ignored until COOL.
REQ-022 On grant, latched evict = 1 -> WB, else -> FILL.
REQ-023 WB: mem_req = 1, mem_we = 1, mem_addr = {evict_addr[ADDR_W-1:4], 4'b0}, mem_wdata = latched block; mem_ack -> FILL next cycle.
REQ-024 FILL: mem_req = 1, mem_we = 0, mem_addr = {load_addr[ADDR_W-1:4], 4'b0}; mem_ack -> capture mem_rdata, go RESP.
REQ-025 mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable from assertion until the mem_ack cycle; mem_req = 0 in IDLE, RESP, COOL.
REQ-026 mem_ack outside WB/FILL SHALL be ignored.
REQ-027 RESP (one cycle): granted port's ready = 1, fill_block = captured data; other ready = 0; -> COOL.
REQ-028 COOL (one cycle): ignore both load inputs (requester drops load after ready); -> IDLE.
REQ-029 Minimum latency load-to-ready: 1 (grant) + memory latency of each transfer + 1 (RESP); ack in the first WB/FILL cycle gives 3 cycles with no evict, 4 with evict.
REQ-030 The ungranted port's request SHALL be held pending, never dropped, and served at the next IDLE.
REQ-031 i_ready and d_ready SHALL never be high together and SHALL never exceed one cycle per grant.
REQ-032 Address bits [3:0] SHALL never reach mem_addr.

Reset
REQ-033 reset low SHALL immediately force IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, fill_block = 0, i_ready = d_ready = 0, busy = 0, round-robin pointer = I (D wins next tie).
REQ-034 Reset mid-transfer SHALL abandon it; a mem_ack arriving after reset release SHALL be ignored.

Verification
REQ-035 D-only load, addr 0x0000_1234, no evict, ack on 2nd FILL cycle with rdata 0xA5..A5 -> one mem read at 0x0000_1230, d_ready one cycle with fill_block 0xA5..A5, i_ready stays 0.
REQ-036 I load with evict, evict_addr 0x0040_8010, load_addr 0x0000_0020 -> write 0x0040_8010 with evict block, then read 0x0000_0020, i_ready after second ack.
REQ-037 I and D assert load in the same cycle after reset -> D served first, then I with no extra IDLE gap beyond COOL; then simultaneous again -> D first (alternation).
REQ-038 mem_ack held low 10 cycles in FILL -> mem_req, mem_addr, mem_we stable all 10 cycles, no ready.
REQ-039 reset pulled low during WB -> mem_req drops immediately; stray mem_ack after release ignored, busy = 0.
REQ-040 Spurious mem_ack in IDLE -> no state change, no ready pulse.
